pdu_down_timer: RTL and testbench
=================================

Name: pdu_down_timer

Overview:
Loadable down-counting timer for the PDU. It is the consumer-side counterpart of the free-running up counter.
- The host loads a start value through a valid/ready handshake.
- The block counts down on prescaled ticks and emits a one-cycle expire pulse at terminal count.
- It supports one-shot and periodic (auto-reload) modes.
- Used for PDU step/run pacing and timeout generation for the single-cycle CPU debug path.

Parameters:
- W, 20, counter width in bits.
- PRESCALE_W, 8, width of the prescale divisor field.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset); one clock domain.
- load_valid  input  1  host offers a new load.
- load_ready  output  1  timer can accept a load; combinational.
- load_value  input  W  start/reload count N; sampled on handshake.
- load_periodic  input  1  mode select, sampled on handshake: 1 = periodic, 0 = one-shot.
- load_prescale  input  PRESCALE_W  divisor P, sampled on handshake; tick every P+1 cycles.
- pause  input  1  level; while high in RUN, ticks are suppressed.
- stop  input  1  single-cycle abort request.
- cnt  output  W  current count value.
- busy  output  1  high when state is RUN.
- expire  output  1  registered, one-cycle pulse at terminal count.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - cnt=0, busy=0, expire=0.
  - Internal reload, mode, prescale and tick registers all 0.
- States: IDLE and RUN. busy = (state==RUN).
- load_ready = (state==IDLE) && !stop. A load is accepted on a rising edge where load_valid && load_ready.
- On load accept:
  - cnt<=N; reload<=N; mode<=load_periodic; P<=load_prescale.
  - Prescale counter<=0; state<=RUN.
- Tick generation: in RUN with pause=0, the prescale counter increments each cycle. A tick fires when the counter equals P; the counter wraps to 0 on the same edge. With pause=1, both the prescale counter and cnt hold.
- Tick in RUN:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0: expire<=1 for exactly one cycle. Then, if periodic, cnt<=reload and stay in RUN. If one-shot, cnt stays 0 and state<=IDLE.
- Timing:
  - Expire period is (N+1)*(P+1) cycles.
  - With P=0 and a load accepted at edge k, expire is high during the cycle after edge k+N+1.
  - N=0 with P=0 expires after edge k+1.
- Priority on any edge: stop > load > tick.
  - stop in RUN: state<=IDLE, cnt<=0, prescale counter<=0, no expire. If the same edge would have expired, expire is suppressed.
  - stop in IDLE: no effect other than blocking a load on that edge.
- No reload while in RUN; reprogramming requires stop and then load.
- Wrap-around: cnt never underflows past 0. Reload restores N exactly, with no residual offset.
- Reset mid-RUN: immediate return to reset values; any pending expire is lost.

Optional Feature:
PDU_TIMER_EXPCNT_EN
- Defined: adds output expire_count [W-1:0].
  - Reset value 0; cleared to 0 on each load accept.
  - Increments on each expire and saturates at all-ones (no wrap).
  - Not cleared by stop.
- Undefined: port and register absent. All other behaviour is identical.

Decomposition:
- Package pdu_timer_pkg:
  - State encoding constants ST_IDLE, ST_RUN.
  - Mode constants MODE_ONESHOT, MODE_PERIODIC.
  - Default widths (20 and 8).
- Sub-module pdu_tick_gen holds the prescale counter.
  - Inputs: clk, rst, enable, clear, P.
  - Output: tick pulse.
  - enable = RUN && !pause; clear = load accept or stop.

Test Plan:
1. Reset release, then load N=3, P=0, one-shot: load_ready=1 in IDLE; busy=1 next cycle; cnt goes 3,2,1,0; one expire pulse; then IDLE with cnt=0 and load_ready=1.
2. Load N=2, P=1, periodic, run 20 cycles: expire every 6 cycles (pulses 6 cycles apart); cnt reloads to 2 after each expire.
3. Pause: N=4, P=0, periodic; pause high for 5 cycles mid-count: cnt frozen; expire delayed by exactly 5 cycles.
4. stop asserted on the same edge cnt==0 would tick: no expire, state IDLE, cnt=0. stop and load_valid together in IDLE: load_ready=0, no load accepted.
5. Async reset (rst=0) asserted mid-RUN between clock edges: busy, cnt and expire go to 0 immediately, without waiting for a clock edge.
6. With PDU_TIMER_EXPCNT_EN: W=4, N=0, P=0, periodic for 20 cycles: expire_count saturates at 15. A subsequent stop plus load clears it to 0.

Source files
------------

// File: rtl/pdu_timer_pkg.sv
// pdu_timer_pkg: shared types and default widths for the PDU down timer.
// Optional feature macro used by the timer: PDU_TIMER_EXPCNT_EN.
package pdu_timer_pkg;

   localparam int unsigned W_DEFAULT          = 20;
   localparam int unsigned PRESCALE_W_DEFAULT = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef enum logic {
      MODE_ONESHOT  = 1'b0,
      MODE_PERIODIC = 1'b1
   } mode_t;

   // Map the host's mode bit onto the mode encoding.
   function automatic mode_t to_mode(input logic periodic);
      return periodic ? MODE_PERIODIC : MODE_ONESHOT;
   endfunction

endpackage

// File: rtl/pdu_tick_gen.sv
// pdu_tick_gen: prescale divider for the PDU down timer.
// Fires a single-cycle tick every p+1 enabled cycles; holds while disabled.
module pdu_tick_gen
   import pdu_timer_pkg::*;
#(
   parameter int unsigned PRESCALE_W = PRESCALE_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] p,
   output logic                  tick
);

   localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] pcnt;
   logic                  at_term;

   // Terminal detect of the prescale counter against the divisor.
   always_comb begin
      at_term = (pcnt == p);
      tick    = enable && at_term;
   end

   // Prescale counter: cleared on load/stop, wraps to 0 on the tick edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
      end else if (clear) begin
         pcnt <= '0;
      end else if (enable) begin
         if (at_term) begin
            pcnt <= '0;
         end else begin
            pcnt <= pcnt + ONE;
         end
      end
   end

endmodule

// File: rtl/pdu_down_timer.sv
// pdu_down_timer: loadable down-counting timer with one-shot/periodic modes.
// Optional feature: define PDU_TIMER_EXPCNT_EN to add the saturating
// expire_count output.
module pdu_down_timer
   import pdu_timer_pkg::*;
#(
   parameter int unsigned W          = W_DEFAULT,
   parameter int unsigned PRESCALE_W = PRESCALE_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [W-1:0]          load_value,
   input  logic                  load_periodic,
   input  logic [PRESCALE_W-1:0] load_prescale,
   input  logic                  pause,
   input  logic                  stop,
   output logic [W-1:0]          cnt,
   output logic                  busy,
`ifdef PDU_TIMER_EXPCNT_EN
   output logic                  expire,
   output logic [W-1:0]          expire_count
`else
   output logic                  expire
`endif
);

   localparam logic [W-1:0] ONE = W'(1);

   state_t                state;
   mode_t                 mode;
   logic [W-1:0]          reload;
   logic [PRESCALE_W-1:0] prescale;

   logic load_accept;
   logic tick_en;
   logic tick_clr;
   logic tick;
   logic fire;

   // Handshake, tick-gen control and terminal-count detection.
   always_comb begin
      load_ready  = (state == ST_IDLE) && !stop;
      load_accept = load_valid && load_ready;
      busy        = (state == ST_RUN);
      tick_en     = (state == ST_RUN) && !pause;
      tick_clr    = load_accept || stop;
      fire        = (state == ST_RUN) && tick && !stop && (cnt == '0);
   end

   pdu_tick_gen #(
      .PRESCALE_W (PRESCALE_W)
   ) u_tick_gen (
      .clk    (clk),
      .rst    (rst),
      .enable (tick_en),
      .clear  (tick_clr),
      .p      (prescale),
      .tick   (tick)
   );

   // Timer FSM: stop beats load beats tick; expire is a registered pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         mode     <= MODE_ONESHOT;
         cnt      <= '0;
         reload   <= '0;
         prescale <= '0;
         expire   <= 1'b0;
      end else begin
         expire <= 1'b0;
         if (stop) begin
            if (state == ST_RUN) begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         end else if (load_accept) begin
            cnt      <= load_value;
            reload   <= load_value;
            mode     <= to_mode(load_periodic);
            prescale <= load_prescale;
            state    <= ST_RUN;
         end else if ((state == ST_RUN) && tick) begin
            if (cnt != '0) begin
               cnt <= cnt - ONE;
            end else begin
               expire <= 1'b1;
               if (mode == MODE_PERIODIC) begin
                  cnt <= reload;
               end else begin
                  state <= ST_IDLE;
               end
            end
         end
      end
   end

`ifdef PDU_TIMER_EXPCNT_EN
   // Saturating count of expire pulses since the last accepted load.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         expire_count <= '0;
      end else if (load_accept) begin
         expire_count <= '0;
      end else if (fire && (expire_count != '1)) begin
         expire_count <= expire_count + ONE;
      end
   end
`else
   logic unused_fire;
   // Terminal detect only feeds the optional expire counter.
   always_comb unused_fire = fire;
`endif

endmodule

// File: tb/tb_pdu_down_timer.sv
// tb_pdu_down_timer: self-checking bench for pdu_down_timer.
module tb_pdu_down_timer;

   localparam int unsigned W  = 20;
   localparam int unsigned PW = 8;

   logic          clk;
   logic          rst_n;
   logic          load_valid;
   logic          load_ready;
   logic [W-1:0]  load_value;
   logic          load_periodic;
   logic [PW-1:0] load_prescale;
   logic          pause;
   logic          stop;
   logic [W-1:0]  cnt;
   logic          busy;
   logic          expire;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic          lv;
      logic [W-1:0]  val;
      logic          per;
      logic [PW-1:0] pre;
      logic          pau;
      logic          stp;
      logic          exp_ready;
      logic [W-1:0]  exp_cnt;
      logic          exp_busy;
      logic          exp_expire;
   } vec_t;

   typedef struct {
      logic [W-1:0] cnt;
      logic         busy;
      logic         expire;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[22];

`ifdef PDU_TIMER_EXPCNT_EN
   logic [W-1:0] expire_count;
   logic         b_lv, b_ready, b_per, b_pause, b_stop, b_busy, b_expire;
   logic [3:0]   b_val, b_cnt, b_ec;
   logic [PW-1:0] b_pre;

   pdu_down_timer #(.W(W), .PRESCALE_W(PW)) u_dut (
      .clk(clk), .rst(rst_n), .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .load_periodic(load_periodic),
      .load_prescale(load_prescale), .pause(pause), .stop(stop), .cnt(cnt),
      .busy(busy), .expire(expire), .expire_count(expire_count));

   pdu_down_timer #(.W(4), .PRESCALE_W(PW)) u_dut4 (
      .clk(clk), .rst(rst_n), .load_valid(b_lv), .load_ready(b_ready),
      .load_value(b_val), .load_periodic(b_per), .load_prescale(b_pre),
      .pause(b_pause), .stop(b_stop), .cnt(b_cnt), .busy(b_busy),
      .expire(b_expire), .expire_count(b_ec));
`else
   pdu_down_timer #(.W(W), .PRESCALE_W(PW)) u_dut (
      .clk(clk), .rst(rst_n), .load_valid(load_valid), .load_ready(load_ready),
      .load_value(load_value), .load_periodic(load_periodic),
      .load_prescale(load_prescale), .pause(pause), .stop(stop), .cnt(cnt),
      .busy(busy), .expire(expire));
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   function automatic vec_t mkv(input int lv, input int val, input int per, input int pre,
                                input int pau, input int stp, input int rdy,
                                input int ecnt, input int ebusy, input int eexp);
      vec_t v;
      v.lv = lv[0];  v.val = val[W-1:0]; v.per = per[0]; v.pre = pre[PW-1:0];
      v.pau = pau[0]; v.stp = stp[0];    v.exp_ready = rdy[0];
      v.exp_cnt = ecnt[W-1:0]; v.exp_busy = ebusy[0]; v.exp_expire = eexp[0];
      return v;
   endfunction

   // Closed-form periodic model: a = un-paused edges since the load edge.
   function automatic exp_t model(input int n, input int p, input int a, input logic active);
      exp_t e;
      int   t, r;
      logic tk;
      tk = active && ((a % (p + 1)) == 0);
      t  = a / (p + 1);
      r  = t % (n + 1);
      e.cnt    = (r == 0) ? n[W-1:0] : W'(n - r);
      e.busy   = 1'b1;
      e.expire = tk && (r == 0) && (t > 0);
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic set_in(input int lv, input int val, input int per, input int pre,
                         input int pau, input int stp);
      load_valid    = lv[0];
      load_value    = val[W-1:0];
      load_periodic = per[0];
      load_prescale = pre[PW-1:0];
      pause         = pau[0];
      stop          = stp[0];
   endtask

   // Push the expected post-edge state, clock once, then pop and compare.
   task automatic cycle_exp(input exp_t e, input string tag);
      exp_t got;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk({tag, ".cnt"},    32'(cnt),    32'(got.cnt));
      chk({tag, ".busy"},   32'(busy),   32'(got.busy));
      chk({tag, ".expire"}, 32'(expire), 32'(got.expire));
   endtask

   task automatic cyc(input int ecnt, input int ebusy, input int eexp, input string tag);
      exp_t e;
      e.cnt = ecnt[W-1:0]; e.busy = ebusy[0]; e.expire = eexp[0];
      cycle_exp(e, tag);
   endtask

   // Drop reset between clock edges and check outputs clear without an edge.
   task automatic async_rst(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      chk({tag, ".cnt"},    32'(cnt),    32'd0);
      chk({tag, ".busy"},   32'(busy),   32'd0);
      chk({tag, ".expire"}, 32'(expire), 32'd0);
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".ready"}, 32'(load_ready), 32'd1);
   endtask

   initial begin
      int last_exp;
      int first_exp;
      int a;
      int n, p;
      logic pz;

      vecs[0]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[1]  = mkv(1, 3, 0, 0, 0, 0, 1, 3, 1, 0);
      vecs[2]  = mkv(0, 0, 0, 0, 0, 0, 0, 2, 1, 0);
      vecs[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      vecs[4]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[6]  = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[7]  = mkv(1, 1, 0, 0, 0, 0, 1, 1, 1, 0);
      vecs[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[9]  = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      vecs[10] = mkv(1, 5, 0, 0, 0, 1, 0, 0, 0, 0);
      vecs[11] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[12] = mkv(1, 7, 1, 3, 0, 0, 1, 7, 1, 0);
      vecs[13] = mkv(0, 0, 0, 0, 0, 0, 0, 7, 1, 0);
      vecs[14] = mkv(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      vecs[15] = mkv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      vecs[16] = mkv(1, 2, 0, 0, 0, 0, 1, 2, 1, 0);
      vecs[17] = mkv(1, 9, 0, 0, 0, 0, 0, 1, 1, 0);
      vecs[18] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      vecs[19] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[20] = mkv(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
      vecs[21] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

`ifdef PDU_TIMER_EXPCNT_EN
      b_lv = 1'b0; b_val = '0; b_per = 1'b0; b_pre = '0; b_pause = 1'b0; b_stop = 1'b0;
`endif
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("reset.cnt",    32'(cnt),        32'd0);
      chk("reset.busy",   32'(busy),       32'd0);
      chk("reset.expire", 32'(expire),     32'd0);
      chk("reset.ready",  32'(load_ready), 32'd1);
      rst_n = 1'b1;

      // Table: one-shot countdown, stop at terminal, stop+load, load in RUN, N=0.
      for (int i = 0; i < 22; i++) begin
         set_in(int'(vecs[i].lv), int'(vecs[i].val), int'(vecs[i].per),
                int'(vecs[i].pre), int'(vecs[i].pau), int'(vecs[i].stp));
         #1;
         chk($sformatf("vec%0d.ready", i), 32'(load_ready), 32'(vecs[i].exp_ready));
         cyc(int'(vecs[i].exp_cnt), int'(vecs[i].exp_busy), int'(vecs[i].exp_expire),
             $sformatf("vec%0d", i));
      end

      // Periodic N=2 P=1: expire every 6 cycles, reload to 2.
      set_in(1, 2, 1, 1, 0, 0);
      cyc(2, 1, 0, "per.load");
      set_in(0, 0, 0, 0, 0, 0);
      last_exp = 0;
      for (int i = 1; i <= 20; i++) begin
         cycle_exp(model(2, 1, i, 1'b1), $sformatf("per.e%0d", i));
         if (expire === 1'b1) begin
            chk($sformatf("per.spacing%0d", i), 32'(i - last_exp), 32'd6);
            last_exp = i;
         end
      end
      chk("per.last_expire", 32'(last_exp), 32'd18);
      set_in(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, "per.stop");

      // Pause N=4 P=0 periodic for 5 cycles: expire moves from edge 5 to 10.
      set_in(1, 4, 1, 0, 0, 0);
      cyc(4, 1, 0, "pause.load");
      a = 0;
      first_exp = 0;
      for (int i = 1; i <= 12; i++) begin
         pz = (i >= 3) && (i <= 7);
         set_in(0, 0, 0, 0, int'(pz), 0);
         if (!pz) a++;
         cycle_exp(model(4, 0, a, !pz), $sformatf("pause.e%0d", i));
         if (expire === 1'b1 && first_exp == 0) first_exp = i;
      end
      chk("pause.first_expire", 32'(first_exp), 32'd10);
      set_in(0, 0, 0, 0, 0, 1);
      cyc(0, 0, 0, "pause.stop");

      // Random periodic runs with random pause against the closed-form model.
      for (int r = 0; r < 4; r++) begin
         n = int'($urandom_range(0, 5));
         p = int'($urandom_range(0, 3));
         set_in(1, n, 1, p, 0, 0);
         cyc(n, 1, 0, $sformatf("rnd%0d.load", r));
         a = 0;
         for (int i = 1; i <= 30; i++) begin
            pz = ($urandom_range(0, 3) == 0);
            set_in(0, 0, 0, 0, int'(pz), 0);
            if (!pz) a++;
            cycle_exp(model(n, p, a, !pz), $sformatf("rnd%0d.e%0d", r, i));
         end
         set_in(0, 0, 0, 0, 0, 1);
         cyc(0, 0, 0, $sformatf("rnd%0d.stop", r));
      end
      set_in(0, 0, 0, 0, 0, 0);

      // Asynchronous reset mid-count and while expire is high.
      set_in(1, 9, 0, 0, 0, 0);
      cyc(9, 1, 0, "arst1.load");
      set_in(0, 0, 0, 0, 0, 0);
      cyc(8, 1, 0, "arst1.run");
      async_rst("arst1");
      set_in(1, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, "arst2.load");
      set_in(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, "arst2.run");
      async_rst("arst2");

`ifdef PDU_TIMER_EXPCNT_EN
      // W=4, N=0, P=0 periodic: expire_count saturates at 15, stop keeps it, load clears it.
      b_lv = 1'b1; b_val = 4'd0; b_per = 1'b1; b_pre = '0;
      @(posedge clk); #1;
      b_lv = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("expcnt.saturate", 32'(b_ec), 32'd15);
      b_stop = 1'b1;
      @(posedge clk); #1;
      b_stop = 1'b0;
      chk("expcnt.after_stop", 32'(b_ec), 32'd15);
      b_lv = 1'b1;
      @(posedge clk); #1;
      b_lv = 1'b0;
      chk("expcnt.after_load", 32'(b_ec), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
